// File: rtl/mux_rr_arbiter.sv
// Round-robin owner selection for a shared 4:1 mux datapath.
// Owner legs a/b/c/d feed y through a one-entry output register with
// valid/ready backpressure. Bursts are capped at MAX_BURST beats per grant.
//
// Handshake: a beat moves into y on any edge where the owner holds req and
// the output register is free (y_valid=0) or being drained (out_ready=1).
// The owner sees this as ack. The consumer takes y on any edge where
// y_valid=1 and out_ready=1.
module mux_rr_arbiter #(
    parameter int W         = 4,
    parameter int MAX_BURST = 4,
    parameter int CW        = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    input  logic         out_ready,
    output logic [3:0]   gnt,
    output logic [3:0]   ack,
    output logic [1:0]   s,
    output logic [W-1:0] y,
    output logic         y_valid,
    output logic         busy
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    state_t         r_state,    w_state;
    logic [1:0]     r_owner,    w_owner;
    logic [1:0]     r_last,     w_last;
    logic [3:0]     r_gnt,      w_gnt;
    logic [1:0]     r_s,        w_s;
    logic [W-1:0]   r_y,        w_y;
    logic           r_y_valid,  w_y_valid;
    logic [CW-1:0]  r_beat_cnt, w_beat_cnt;

    logic [1:0]     w_pick;
    logic           w_pick_ok;
    logic [W-1:0]   w_mux;
    logic           w_accept;

    // Round-robin search starting just after the last released owner.
    always_comb begin
        w_pick    = 2'd0;
        w_pick_ok = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!w_pick_ok && req[2'(r_last + 2'(k))]) begin
                w_pick    = 2'(r_last + 2'(k));
                w_pick_ok = 1'b1;
            end
        end
    end

    // The shared 4:1 datapath mux, steered by the registered select.
    always_comb begin
        case (r_s)
            2'd0:    w_mux = a;
            2'd1:    w_mux = b;
            2'd2:    w_mux = c;
            default: w_mux = d;
        endcase
    end

    assign w_accept = (r_state == GRANT) && req[r_owner] && (!r_y_valid || out_ready);

    // Next-state, grant bookkeeping and output-register update.
    always_comb begin
        w_state    = r_state;
        w_owner    = r_owner;
        w_last     = r_last;
        w_gnt      = r_gnt;
        w_s        = r_s;
        w_y        = r_y;
        w_y_valid  = r_y_valid;
        w_beat_cnt = r_beat_cnt;

        // A taken beat is either replaced by a new one or drained.
        if (w_accept) begin
            w_y       = w_mux;
            w_y_valid = 1'b1;
        end else if (r_y_valid && out_ready) begin
            w_y_valid = 1'b0;
        end

        case (r_state)
            IDLE: begin
                if (w_pick_ok) begin
                    w_state    = GRANT;
                    w_owner    = w_pick;
                    w_s        = w_pick;
                    w_gnt      = 4'b0001 << w_pick;
                    w_beat_cnt = '0;
                end
            end
            GRANT: begin
                if (!req[r_owner]) begin
                    w_state = IDLE;
                    w_gnt   = 4'b0000;
                    w_last  = r_owner;
                end else if (w_accept) begin
                    if (r_beat_cnt == LAST_BEAT) begin
                        // Final beat of the burst is captured while releasing.
                        w_state    = IDLE;
                        w_gnt      = 4'b0000;
                        w_last     = r_owner;
                        w_beat_cnt = '0;
                    end else begin
                        w_beat_cnt = r_beat_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state = IDLE;
                w_gnt   = 4'b0000;
            end
        endcase
    end

    // State register; reset drops any beat held in y immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_owner    <= 2'd0;
            r_last     <= 2'd3;
            r_gnt      <= 4'b0000;
            r_s        <= 2'd0;
            r_y        <= '0;
            r_y_valid  <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state;
            r_owner    <= w_owner;
            r_last     <= w_last;
            r_gnt      <= w_gnt;
            r_s        <= w_s;
            r_y        <= w_y;
            r_y_valid  <= w_y_valid;
            r_beat_cnt <= w_beat_cnt;
        end
    end

    assign gnt     = r_gnt;
    assign ack     = r_gnt & {4{w_accept}};
    assign s       = r_s;
    assign y       = r_y;
    assign y_valid = r_y_valid;
    assign busy    = (r_state == GRANT);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus randomized traffic,
// checked against a behavioural model and a beat scoreboard.
module tb_mux_rr_arbiter;

    localparam int W         = 4;
    localparam int MAX_BURST = 4;
    localparam int CW        = 4;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req;
    logic [W-1:0] a, b, c, d;
    logic         out_ready;
    logic [3:0]   gnt, ack;
    logic [1:0]   s;
    logic [W-1:0] y;
    logic         y_valid, busy;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];

    // Behavioural model: who owns the mux, how many beats it has moved,
    // who was released last, and whether a beat waits for the consumer.
    int m_busy  = 0;
    int m_owner = 0;
    int m_last  = 3;
    int m_beats = 0;
    int m_s     = 0;
    bit m_yv    = 0;

    mux_rr_arbiter #(.W(W), .MAX_BURST(MAX_BURST), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .a(a), .b(b), .c(c), .d(d),
        .out_ready(out_ready),
        .gnt(gnt), .ack(ack), .s(s), .y(y),
        .y_valid(y_valid), .busy(busy)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        req   = 4'b0000;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] leg(input int i);
        case (i)
            0:       return a;
            1:       return b;
            2:       return c;
            default: return d;
        endcase
    endfunction

    // ---------------- reference model ----------------
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 0; m_owner = 0; m_last = 3; m_beats = 0; m_s = 0; m_yv = 0;
                exp_q.delete();
            end else if (m_busy == 0) begin
                bit found;
                found = 0;
                if (m_yv && out_ready) m_yv = 0;
                for (int k = 1; k <= 4; k++) begin
                    int i;
                    i = (m_last + k) % 4;
                    if (!found && req[i]) begin
                        found = 1; m_owner = i; m_s = i; m_beats = 0; m_busy = 1;
                    end
                end
            end else begin
                if (!req[m_owner]) begin
                    m_busy = 0;
                    m_last = m_owner;
                    if (m_yv && out_ready) m_yv = 0;
                end else if (!m_yv || out_ready) begin
                    exp_q.push_back(leg(m_owner));
                    m_yv = 1;
                    m_beats++;
                    if (m_beats == MAX_BURST) begin
                        m_busy = 0;
                        m_last = m_owner;
                    end
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                logic [3:0] e_gnt, e_ack;
                e_gnt = (m_busy != 0) ? (4'b0001 << m_owner) : 4'b0000;
                e_ack = ((m_busy != 0) && req[m_owner] && (!m_yv || out_ready)) ? e_gnt : 4'b0000;
                check("gnt",     gnt,     e_gnt);
                check("ack",     ack,     e_ack);
                check("s",       s,       m_s);
                check("busy",    busy,    (m_busy != 0));
                check("y_valid", y_valid, m_yv);
                if (y_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL y_take actual=%0h expected=<none queued> at %0t", y, $time);
                    end else begin
                        check("y_take", y, exp_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int acks;
        rst_n = 1'b0; req = 4'b0000; out_ready = 1'b1;
        a = '0; b = '0; c = '0; d = '0;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_ack", ack, 0);
        check("rst_s", s, 0);
        check("rst_y", y, 0);
        check("rst_y_valid", y_valid, 0);
        check("rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;

        // Single requester c=7 held for six cycles.
        tick();
        req = 4'b0100; c = 4'd7;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) begin
                check("single_gnt", gnt, 4'b0100);
                check("single_s", s, 2);
            end
            if (i == 1) begin
                check("single_y", y, 7);
                check("single_y_valid", y_valid, 1);
            end
            if (i == 4) check("single_gap_gnt", gnt, 4'b0000);
            if (i == 5) check("single_regrant", gnt, 4'b0100);
            if (i < 5 && ack != 0) acks++;
        end
        check("single_ack_count", acks, 4);
        do_reset();

        // Backpressure on owner 0.
        out_ready = 1'b1;
        req = 4'b0001; a = 4'd5;
        tick();
        tick();
        out_ready = 1'b0; a = 4'd6;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ack", ack, 0);
            check("bp_y", y, 5);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_resume_ack", ack, 4'b0001);
        tick();
        check("bp_resume_y", y, 6);
        do_reset();

        // Early release by owner 1 with 2 and 3 waiting.
        out_ready = 1'b1;
        req = 4'b1110;
        tick();
        check("early_gnt", gnt, 4'b0010);
        tick();
        tick();
        req = 4'b1100;
        tick();
        check("early_release_gnt", gnt, 4'b0000);
        tick();
        check("early_next_gnt", gnt, 4'b0100);
        do_reset();

        // Asynchronous reset between edges while owner 1 holds a beat.
        req = 4'b0010; b = 4'd9;
        tick();
        tick();
        check("async_pre_y_valid", y_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_y", y, 0);
        check("async_y_valid", y_valid, 0);
        check("async_gnt", gnt, 0);
        check("async_s", s, 0);
        check("async_busy", busy, 0);
        req = 4'b1010;
        tick();
        rst_n = 1'b1;
        tick();
        check("async_first_gnt", gnt, 4'b0010);
        do_reset();

        // Randomized traffic; requests persist with occasional toggles.
        for (int n = 0; n < 800; n++) begin
            tick();
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 4) == 0) req[i] = ~req[i];
            a = W'($urandom);
            b = W'($urandom);
            c = W'($urandom);
            d = W'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
        end

        // Drain whatever is still in flight.
        req = 4'b0000;
        out_ready = 1'b1;
        repeat (6) tick();
        check("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
